cn_msg_collector: RTL and testbench

//  Check-node input stage. Accepts one W-bit two's-complement variable-to-check

---
 rtl/cn_msg_collector.sv | 141 ++++++++++++++
 tb/tb_cn_msg_collector.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cn_msg_collector.sv
`default_nettype none
// ============================================================================
//  Module   : cn_msg_collector
//  Purpose  : Check-node input stage. Splits each two's-complement V2C message
//             into sign and saturated magnitude and packs Wc of them into a
//             parallel absL/signL row. Two ping-pong banks let the next row
//             be collected while the previous one is held for the consumer.
//  Option   : MIN_TRACK_EN adds min1/min2/min1_idx outputs.
//  Revision : 1.0  initial release
// ============================================================================
module cn_msg_collector #(
   parameter int W    = 10,
   parameter int Wabs = W - 1,
   parameter int Wc   = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_msg,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [Wc*Wabs-1:0]   absL,
   output logic [Wc-1:0]        signL,
   output logic                 sgn_par,
   output logic                 err_len
`ifdef MIN_TRACK_EN
   ,
   output logic [Wabs-1:0]         min1,
   output logic [Wabs-1:0]         min2,
   output logic [$clog2(Wc)-1:0]   min1_idx
`endif
);

   localparam int CW = $clog2(Wc);

   logic [Wc*Wabs-1:0] abs_bank  [2];
   logic [Wc-1:0]      sign_bank [2];
   logic [1:0]         full;
   logic               wr_bank;
   logic               rd_bank;
   logic [CW-1:0]      count;

   logic               wr_fire;
   logic               rd_fire;
   logic               last_beat;
   logic [W-1:0]       neg_msg;
   logic [Wabs-1:0]    mag;
   logic               sign;

   assign in_ready  = !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign wr_fire   = in_valid && in_ready;
   assign rd_fire   = out_valid && out_ready;
   assign last_beat = (count == CW'(Wc - 1));

   // Sign/magnitude split; the most negative code has no positive twin and
   // is saturated to the largest magnitude.
   assign neg_msg = -in_msg;
   assign sign    = in_msg[W-1];
   assign mag     = !sign ? in_msg[Wabs-1:0]
                  : (neg_msg[W-1] ? {Wabs{1'b1}} : neg_msg[Wabs-1:0]);

   // Presented row is whatever the read bank holds.
   assign absL    = abs_bank[rd_bank];
   assign signL   = sign_bank[rd_bank];
   assign sgn_par = ^sign_bank[rd_bank];

   // Bank fill, row close, bank release and length-check pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         abs_bank[0]  <= '0;
         abs_bank[1]  <= '0;
         sign_bank[0] <= '0;
         sign_bank[1] <= '0;
         full         <= 2'b00;
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
         count        <= '0;
         err_len      <= 1'b0;
      end else begin
         err_len <= 1'b0;
         if (wr_fire) begin
            abs_bank[wr_bank][count*Wabs +: Wabs] <= mag;
            sign_bank[wr_bank][count]             <= sign;
            err_len                               <= (in_last != last_beat);
            if (last_beat) begin
               full[wr_bank] <= 1'b1;
               count         <= '0;
               wr_bank       <= ~wr_bank;
            end else begin
               count <= count + 1'b1;
            end
         end
         // A write can only target a non-full bank and a read only a full
         // one, so both may act in the same cycle on different banks.
         if (rd_fire) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

`ifdef MIN_TRACK_EN
   logic [Wabs-1:0] min1_bank [2];
   logic [Wabs-1:0] min2_bank [2];
   logic [CW-1:0]   idx_bank  [2];

   assign min1     = min1_bank[rd_bank];
   assign min2     = min2_bank[rd_bank];
   assign min1_idx = idx_bank[rd_bank];

   // Incremental two-minimum tracking; strict compares keep the earlier
   // index as min1 on ties and push a later equal value into min2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min1_bank[0] <= '1;
         min1_bank[1] <= '1;
         min2_bank[0] <= '1;
         min2_bank[1] <= '1;
         idx_bank[0]  <= '0;
         idx_bank[1]  <= '0;
      end else if (wr_fire) begin
         if (count == '0) begin
            min1_bank[wr_bank] <= mag;
            min2_bank[wr_bank] <= '1;
            idx_bank[wr_bank]  <= '0;
         end else if (mag < min1_bank[wr_bank]) begin
            min2_bank[wr_bank] <= min1_bank[wr_bank];
            min1_bank[wr_bank] <= mag;
            idx_bank[wr_bank]  <= count;
         end else if (mag < min2_bank[wr_bank]) begin
            min2_bank[wr_bank] <= mag;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cn_msg_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cn_msg_collector
//  Purpose  : Randomised bench for cn_msg_collector against a row/queue
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cn_msg_collector;

   localparam int W    = 10;
   localparam int Wabs = W - 1;
   localparam int Wc   = 18;
   localparam int CW   = $clog2(Wc);

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [W-1:0]       in_msg = '0;
   logic               in_last = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [Wc*Wabs-1:0] absL;
   logic [Wc-1:0]      signL;
   logic               sgn_par;
   logic               err_len;
`ifdef MIN_TRACK_EN
   logic [Wabs-1:0]    min1;
   logic [Wabs-1:0]    min2;
   logic [CW-1:0]      min1_idx;
`endif

   always #5 clk = ~clk;

   cn_msg_collector #(.W(W), .Wabs(Wabs), .Wc(Wc)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_msg    (in_msg),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .absL      (absL),
      .signL     (signL),
      .sgn_par   (sgn_par),
      .err_len   (err_len)
`ifdef MIN_TRACK_EN
      ,
      .min1      (min1),
      .min2      (min2),
      .min1_idx  (min1_idx)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: rows in progress and completed rows awaiting the consumer.
   int                 m_count = 0;
   logic [Wc*Wabs-1:0] m_abs   = '0;
   logic [Wc-1:0]      m_sign  = '0;
   logic [Wc*Wabs-1:0] q_abs[$];
   logic [Wc-1:0]      q_sign[$];
   bit                 m_err   = 1'b0;

   function automatic logic [Wabs-1:0] mag_of(input logic [W-1:0] m);
      int v;
      int a;
      v = $signed(m);
      a = (v < 0) ? -v : v;
      if (a > (2**Wabs) - 1) a = (2**Wabs) - 1;
      return Wabs'(a);
   endfunction

   function automatic bit parity_of(input logic [Wc-1:0] s);
      int c;
      c = 0;
      for (int i = 0; i < Wc; i++) c += int'(s[i]);
      return bit'(c % 2);
   endfunction

   function automatic void row_min(input logic [Wc*Wabs-1:0] r,
                                   output int m1, output int m2, output int ix);
      int v;
      m1 = 1 << 30;
      ix = 0;
      for (int i = 0; i < Wc; i++) begin
         v = int'(r[i*Wabs +: Wabs]);
         if (v < m1) begin m1 = v; ix = i; end
      end
      m2 = (2**Wabs) - 1;
      for (int i = 0; i < Wc; i++) begin
         v = int'(r[i*Wabs +: Wabs]);
         if (i != ix && v < m2) m2 = v;
      end
   endfunction

   task automatic check_outputs();
      int m1, m2, ix;
      chk("in_ready",  in_ready,  q_abs.size() < 2);
      chk("out_valid", out_valid, q_abs.size() > 0);
      chk("err_len",   err_len,   m_err);
      if (q_abs.size() > 0) begin
         chk("absL",    absL,    q_abs[0]);
         chk("signL",   signL,   q_sign[0]);
         chk("sgn_par", sgn_par, parity_of(q_sign[0]));
         row_min(q_abs[0], m1, m2, ix);
`ifdef MIN_TRACK_EN
         chk("min1",     min1,     Wabs'(m1));
         chk("min2",     min2,     Wabs'(m2));
         chk("min1_idx", min1_idx, CW'(ix));
`endif
      end
   endtask

   // One clock cycle: check current outputs, drive inputs, advance the model.
   // in_last follows the true row end, and is additionally raised on beat extra_last.
   task automatic step(input bit v, input logic [W-1:0] m, input int extra_last, input bit ordy);
      bit acc;
      bit take;
      @(negedge clk);
      check_outputs();
      in_valid  = v;
      in_msg    = m;
      in_last   = (m_count == Wc - 1) || (m_count == extra_last);
      out_ready = ordy;
      acc  = v && (q_abs.size() < 2);
      take = ordy && (q_abs.size() > 0);
      if (take) begin
         void'(q_abs.pop_front());
         void'(q_sign.pop_front());
      end
      m_err = acc && (in_last != (m_count == Wc - 1));
      if (acc) begin
         m_abs[m_count*Wabs +: Wabs] = mag_of(m);
         m_sign[m_count]             = m[W-1];
         m_count++;
         if (m_count == Wc) begin
            q_abs.push_back(m_abs);
            q_sign.push_back(m_sign);
            m_count = 0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      q_abs.delete();
      q_sign.delete();
      m_count = 0;
      m_err   = 1'b0;
      check_outputs();
      chk("rst_absL",    absL,    '0);
      chk("rst_signL",   signL,   '0);
      chk("rst_sgn_par", sgn_par, '0);
`ifdef MIN_TRACK_EN
      chk("rst_min1",     min1,     {Wabs{1'b1}});
      chk("rst_min2",     min2,     {Wabs{1'b1}});
      chk("rst_min1_idx", min1_idx, '0);
`endif
      @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic logic [W-1:0] rnd_msg();
      case ($urandom % 8)
         0:       return 10'h200;
         1:       return 10'h1FF;
         2:       return '0;
         default: return W'($urandom);
      endcase
   endfunction

   function automatic logic [W-1:0] signed_mag(input int mg);
      return ($urandom % 2 == 1) ? W'(-mg) : W'(mg);
   endfunction

   initial begin
      int dir [5];
      int minv [4];
      dir  = '{5, -3, 0, -512, 511};
      minv = '{9, 4, 4, 7};

      do_reset();

      // Directed first row, then drain.
      for (int k = 0; k < Wc; k++)
         step(1'b1, (k < 5) ? W'(dir[k]) : rnd_msg(), -1, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b0, '0, -1, 1'b1);

      // Consumer stalled: both banks fill, then release.
      for (int k = 0; k < 40; k++) step(1'b1, rnd_msg(), -1, 1'b0);
      for (int k = 0; k < 4; k++)  step(1'b0, '0, -1, 1'b1);

      // Continuous streaming.
      for (int k = 0; k < 10*Wc; k++) step(1'b1, rnd_msg(), -1, 1'b1);
      for (int k = 0; k < 3; k++)     step(1'b0, '0, -1, 1'b1);

      // Early in_last on beat 10: advisory only.
      for (int k = 0; k < Wc + 3; k++) step(k < Wc, rnd_msg(), 10, 1'b1);

      // Reset part way through a row; next row starts fresh.
      for (int k = 0; k < 7; k++) step(1'b1, rnd_msg(), -1, 1'b1);
      do_reset();
      for (int k = 0; k < Wc + 3; k++) step(k < Wc, rnd_msg(), -1, 1'b1);

      // Two-minimum pattern with ties.
      for (int k = 0; k < Wc; k++)
         step(1'b1, (k < 4) ? W'(minv[k]) : signed_mag(int'($urandom_range(8, 511))), -1, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, '0, -1, 1'b1);

      // Random traffic with random back-pressure and stray in_last.
      for (int k = 0; k < 600; k++)
         step(($urandom % 4) != 0, rnd_msg(),
              (($urandom % 8) == 0) ? int'($urandom % Wc) : -1,
              ($urandom % 3) != 0);
      for (int k = 0; k < 6; k++) step(1'b0, '0, -1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
